// File: rtl/br_generator.sv
// br_generator: baud-rate strobe generator for the UART.
// Divides the system clock into a one-cycle oversample strobe (o_tick) and
// a one-cycle bit strobe (o_bit_tick) on every OVERSAMPLE-th o_tick. The
// divisor starts at DEFAULT_DIV and may be replaced at run time.
module br_generator #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int BAUD_RATE   = 19200,
   parameter int OVERSAMPLE  = 16,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_div_load,
   input  logic [DIV_W-1:0] i_divisor,
   output logic             o_tick,
   output logic             o_bit_tick,
   output logic [DIV_W-1:0] o_divisor
);

   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   // Parameter sanity: a zero or oversized reset divisor, or no oversampling,
   // cannot produce a meaningful strobe.
   if (OVERSAMPLE < 1) begin : g_bad_oversample
      $error("br_generator: OVERSAMPLE must be at least 1");
   end
   if (DEFAULT_DIV == 0) begin : g_bad_div_zero
      $error("br_generator: DEFAULT_DIV must be non-zero");
   end
   if ((longint'(DEFAULT_DIV) >> DIV_W) != 0) begin : g_bad_div_wide
      $error("br_generator: DEFAULT_DIV does not fit in DIV_W bits");
   end

   logic [DIV_W-1:0] tick_cnt;
   logic [OS_W-1:0]  os_cnt;
   logic [DIV_W-1:0] div_last;
   logic [DIV_W-1:0] div_next;

   // Terminal count of the tick counter and the clamped load value (0 -> 1).
   always_comb begin
      div_last = o_divisor - DIV_W'(1);
      div_next = (i_divisor == '0) ? DIV_W'(1) : i_divisor;
   end

   // Divisor register, both counters and the registered strobes. A load wins
   // over counting and restarts the period from zero; enable low freezes the
   // counters and silences the strobes.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         tick_cnt   <= '0;
         os_cnt     <= '0;
         o_tick     <= 1'b0;
         o_bit_tick <= 1'b0;
         o_divisor  <= DIV_RST;
      end else if (i_div_load) begin
         tick_cnt   <= '0;
         os_cnt     <= '0;
         o_tick     <= 1'b0;
         o_bit_tick <= 1'b0;
         o_divisor  <= div_next;
      end else if (i_enable) begin
         if (tick_cnt == div_last) begin
            tick_cnt <= '0;
            o_tick   <= 1'b1;
            if (os_cnt == OS_LAST) begin
               os_cnt     <= '0;
               o_bit_tick <= 1'b1;
            end else begin
               os_cnt     <= os_cnt + OS_W'(1);
               o_bit_tick <= 1'b0;
            end
         end else begin
            tick_cnt   <= tick_cnt + DIV_W'(1);
            o_tick     <= 1'b0;
            o_bit_tick <= 1'b0;
         end
      end else begin
         o_tick     <= 1'b0;
         o_bit_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_br_generator.sv
// tb_br_generator: checks br_generator against a counting model that tracks
// enabled edges since the last restart and derives strobes by modulo.
module tb_br_generator;

   localparam int CLK_FREQ   = 5_000_000;
   localparam int BAUD_RATE  = 19200;
   localparam int OVERSAMPLE = 16;
   localparam int DIV_W      = 16;
   localparam int DEF_DIV    = 16;

   logic             i_clock    = 1'b0;
   logic             i_reset    = 1'b1;
   logic             i_enable   = 1'b0;
   logic             i_div_load = 1'b0;
   logic [DIV_W-1:0] i_divisor  = '0;
   logic             o_tick;
   logic             o_bit_tick;
   logic [DIV_W-1:0] o_divisor;

   br_generator #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE),
      .DIV_W     (DIV_W)
   ) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_enable  (i_enable),
      .i_div_load(i_div_load),
      .i_divisor (i_divisor),
      .o_tick    (o_tick),
      .o_bit_tick(o_bit_tick),
      .o_divisor (o_divisor)
   );

   always #100 i_clock = ~i_clock;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: enabled edges since the last reset/load, current divisor.
   longint m_n = 0;
   int     m_d = DEF_DIV;
   logic   m_tick = 1'b0;
   logic   m_bit  = 1'b0;

   typedef struct {
      string       name;
      logic        en;
      logic        ld;
      logic [15:0] dv;
      int          cycles;
      int          exp_ticks;
      int          exp_bits;
      int          exp_div;
   } seg_t;

   seg_t segs[9];

   task automatic check_out(input string name, input logic tk, input logic bt, input int dv);
      vectors++;
      if (o_tick !== tk || o_bit_tick !== bt || o_divisor !== dv[DIV_W-1:0]) begin
         miscompares++;
         $display("FAIL %s: got tick=%0b bit=%0b div=%0d, expected tick=%0b bit=%0b div=%0d",
                  name, o_tick, o_bit_tick, o_divisor, tk, bt, dv);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input logic en, input logic ld, input logic [15:0] dv, input string name);
      i_enable   = en;
      i_div_load = ld;
      i_divisor  = dv;
      @(posedge i_clock);
      #1;
      if (ld) begin
         m_d    = (dv == 0) ? 1 : int'(dv);
         m_n    = 0;
         m_tick = 1'b0;
         m_bit  = 1'b0;
      end else if (en) begin
         m_n++;
         m_tick = ((m_n % m_d) == 0);
         m_bit  = ((m_n % (m_d * OVERSAMPLE)) == 0);
      end else begin
         m_tick = 1'b0;
         m_bit  = 1'b0;
      end
      check_out(name, m_tick, m_bit, m_d);
   endtask

   initial begin
      int ticks;
      int bits;
      int first_tick;
      int first_bit;
      int gap;

      segs[0] = '{"load4",     1'b1, 1'b1, 16'd4, 1,   0,  0, 4};
      segs[1] = '{"div4_run",  1'b1, 1'b0, 16'd0, 64,  16, 1, 4};
      segs[2] = '{"idle",      1'b0, 1'b0, 16'd0, 10,  0,  0, 4};
      segs[3] = '{"load0_dis", 1'b0, 1'b1, 16'd0, 1,   0,  0, 1};
      segs[4] = '{"div1_run",  1'b1, 1'b0, 16'd0, 32,  32, 2, 1};
      segs[5] = '{"load1",     1'b1, 1'b1, 16'd1, 1,   0,  0, 1};
      segs[6] = '{"div1_run2", 1'b1, 1'b0, 16'd0, 16,  16, 1, 1};
      segs[7] = '{"load7_dis", 1'b0, 1'b1, 16'd7, 1,   0,  0, 7};
      segs[8] = '{"div7_run",  1'b1, 1'b0, 16'd0, 112, 16, 1, 7};

      // Reset state
      #250;
      check_out("reset_state", 1'b0, 1'b0, DEF_DIV);
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      m_n = 0;
      m_d = DEF_DIV;

      // Tick period from reset release
      ticks = 0; bits = 0; first_tick = -1; first_bit = -1;
      for (int e = 1; e <= 512; e++) begin
         step(1'b1, 1'b0, 16'd0, "period");
         if (o_tick) begin
            ticks++;
            if (first_tick < 0) first_tick = e;
         end
         if (o_bit_tick) begin
            bits++;
            if (first_bit < 0) first_bit = e;
         end
      end
      check_int("first_tick_edge", first_tick, 16);
      check_int("first_bit_edge", first_bit, 256);
      check_int("ticks_in_512", ticks, 32);
      check_int("bits_in_512", bits, 2);

      // Enable gating with the tick counter at 10
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 16'd0, "pre_gap");
      ticks = 0;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 16'd0, "gap");
         ticks += o_tick + o_bit_tick;
      end
      check_int("strobes_in_gap", ticks, 0);
      gap = -1;
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 1'b0, 16'd0, "resume");
         if (o_tick) begin
            gap = k;
            break;
         end
      end
      check_int("resume_to_tick", gap, 6);

      // Table of segments: loads, edge divisors, disabled loads
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'd0, "midcount");
      for (int s = 0; s < 9; s++) begin
         ticks = 0; bits = 0;
         for (int c = 0; c < segs[s].cycles; c++) begin
            step(segs[s].en, segs[s].ld, segs[s].dv, segs[s].name);
            ticks += o_tick;
            bits  += o_bit_tick;
         end
         check_int({segs[s].name, "_ticks"}, ticks, segs[s].exp_ticks);
         check_int({segs[s].name, "_bits"}, bits, segs[s].exp_bits);
         check_int({segs[s].name, "_div"}, int'(o_divisor), segs[s].exp_div);
      end

      // Load on the wrap edge: no tick, new period from zero
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'd0, "to_wrap");
      step(1'b1, 1'b1, 16'd5, "collide");
      check_int("collide_tick", int'(o_tick), 0);
      gap = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, 16'd0, "after_collide");
         if (o_tick) begin
            gap = k;
            break;
         end
      end
      check_int("collide_first_tick", gap, 5);

      // Asynchronous reset while strobes are high
      step(1'b1, 1'b1, 16'd1, "ld_cont");
      step(1'b1, 1'b0, 16'd0, "cont");
      check_int("cont_tick_high", int'(o_tick), 1);
      #50;
      i_reset = 1'b1;
      #1;
      check_out("async_reset", 1'b0, 1'b0, DEF_DIV);
      @(posedge i_clock);
      #1;
      check_out("held_reset", 1'b0, 1'b0, DEF_DIV);
      i_reset = 1'b0;
      m_n = 0;
      m_d = DEF_DIV;

      // Randomised enable / load traffic
      for (int c = 0; c < 4000; c++) begin
         logic        en;
         logic        ld;
         logic [15:0] dv;
         int          r;
         en = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 49) == 0);
         r  = $urandom_range(0, 9);
         dv = (r == 0) ? 16'd0 : (r == 1) ? 16'd1 : 16'($urandom_range(2, 12));
         step(en, ld, dv, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
